// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and level sizing for the pipelined mux tree
package mux_pkg;

  localparam int MAX_SEL_W = 6;

  // Words produced by tree level k of a 2**sel_w input tree
  function automatic int level_words(input int sel_w, input int k);
    return (1 << sel_w) >> (k + 1);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// rtl/mux_tree_stage.sv - one 2:1 tree level with optional valid/ready register
module mux_tree_stage #(
  parameter int DATA_W   = 8,
  parameter int IN_WORDS = 2,
  parameter int SEL_W    = 1,
  parameter int LEVEL    = 0,
  parameter int REG      = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_WORDS*DATA_W-1:0]         up_data,
  input  logic [SEL_W-1:0]                   up_sel,
  input  logic                               up_valid,
  output logic                               up_ready,
  output logic [(IN_WORDS/2)*DATA_W-1:0]     dn_data,
  output logic [SEL_W-1:0]                   dn_sel,
  output logic                               dn_valid,
  input  logic                               dn_ready
);

  localparam int OUT_WORDS = IN_WORDS / 2;

  logic [OUT_WORDS*DATA_W-1:0] pick;

  // Pairwise select: sel bit LEVEL picks the odd word of each adjacent pair
  always_comb begin
    pick = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      pick[i*DATA_W +: DATA_W] = up_sel[LEVEL] ? up_data[(2*i+1)*DATA_W +: DATA_W]
                                               : up_data[(2*i)*DATA_W +: DATA_W];
    end
  end

  if (REG != 0) begin : g_reg
    logic                        v;
    logic [OUT_WORDS*DATA_W-1:0] data_q;
    logic [SEL_W-1:0]            sel_q;

    // An empty stage can always take a word, even if downstream is stalled
    assign up_ready = dn_ready || !v;

    // Load on ready (data is don't-care when the incoming valid is low), hold otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v      <= 1'b0;
        data_q <= '0;
        sel_q  <= '0;
      end else if (up_ready) begin
        v      <= up_valid;
        data_q <= pick;
        sel_q  <= up_sel;
      end
    end

    assign dn_data  = data_q;
    assign dn_sel   = sel_q;
    assign dn_valid = v;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk | rst;
    assign up_ready       = dn_ready;
    assign dn_data        = pick;
    assign dn_sel         = up_sel;
    assign dn_valid       = up_valid;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - parametrised N:1 mux tree with optional per-level pipelining
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int PIPE   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [(1<<SEL_W)*DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]                 in_sel,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [SEL_W-1:0]                 out_idx,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int N    = 1 << SEL_W;
  localparam int LAST = SEL_W - 1;

  if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_sel_w_check
    $error("mux_tree_pipe: SEL_W must be within 1..MAX_SEL_W");
  end

  // Level k halves the word count; with PIPE=0 only the final level is registered
  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int IN_WORDS  = N >> k;
    localparam int OUT_WORDS = level_words(SEL_W, k);

    logic [IN_WORDS*DATA_W-1:0]  up_data;
    logic [SEL_W-1:0]            up_sel;
    logic                        up_valid;
    logic                        up_ready;
    logic [OUT_WORDS*DATA_W-1:0] dn_data;
    logic [SEL_W-1:0]            dn_sel;
    logic                        dn_valid;
    logic                        dn_ready;

    if (k == 0) begin : g_head
      assign up_data  = in_data;
      assign up_sel   = in_sel;
      assign up_valid = in_valid;
    end else begin : g_link
      assign up_data  = g_lvl[k-1].dn_data;
      assign up_sel   = g_lvl[k-1].dn_sel;
      assign up_valid = g_lvl[k-1].dn_valid;
    end

    if (k == LAST) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_lvl[k+1].up_ready;
    end

    mux_tree_stage #(
      .DATA_W   (DATA_W),
      .IN_WORDS (IN_WORDS),
      .SEL_W    (SEL_W),
      .LEVEL    (k),
      .REG      ((PIPE != 0 || k == LAST) ? 1 : 0)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_data  (up_data),
      .up_sel   (up_sel),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .dn_data  (dn_data),
      .dn_sel   (dn_sel),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready)
    );
  end

  assign in_ready  = g_lvl[0].up_ready;
  assign out_data  = g_lvl[LAST].dn_data;
  assign out_idx   = g_lvl[LAST].dn_sel;
  assign out_valid = g_lvl[LAST].dn_valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - scoreboard bench for the pipelined mux tree
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] a_in_data;
  logic [2:0]  a_in_sel;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_out_data;
  logic [2:0]  a_out_idx;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [31:0] b_in_data;
  logic        b_in_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_out_data;
  logic        b_out_idx;
  logic        b_out_valid;
  logic        b_out_ready;

  logic [10:0] qa[$];
  logic [16:0] qb[$];
  logic [10:0] ea;
  logic [16:0] eb;

  mux_tree_pipe #(.DATA_W(8), .SEL_W(3), .PIPE(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_tree_pipe #(.DATA_W(16), .SEL_W(1), .PIPE(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Scoreboard: push on accepted input, pop and compare on accepted output
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && a_out_ready) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_bad++;
          $display("FAIL a_unexpected_out: got idx=%0d data=%h, expected no output", a_out_idx, a_out_data);
        end else begin
          ea = qa.pop_front();
          if ({a_out_idx, a_out_data} !== ea) begin
            n_bad++;
            $display("FAIL a_out: got idx=%0d data=%h, expected idx=%0d data=%h",
                     a_out_idx, a_out_data, ea[10:8], ea[7:0]);
          end
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back({a_in_sel, a_in_data[a_in_sel*8 +: 8]});
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected_out: got idx=%0d data=%h, expected no output", b_out_idx, b_out_data);
        end else begin
          eb = qb.pop_front();
          if ({b_out_idx, b_out_data} !== eb) begin
            n_bad++;
            $display("FAIL b_out: got idx=%0d data=%h, expected idx=%0d data=%h",
                     b_out_idx, b_out_data, eb[16], eb[15:0]);
          end
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back({b_in_sel, b_in_data[b_in_sel*16 +: 16]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int j = 0; j < 8; j++) a_in_data[j*8 +: 8] = 8'hA0 + 8'(j);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %b, expected 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_bad++; $display("FAIL reset_a_out_data: got %h, expected 00", a_out_data); end
    n_cmp++; if (a_out_idx !== 3'd0) begin n_bad++; $display("FAIL reset_a_out_idx: got %0d, expected 0", a_out_idx); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid: got %b, expected 0", b_out_valid); end
    n_cmp++; if (b_out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_b_out_data: got %h, expected 0000", b_out_data); end
    rst = 1'b0;
    tick();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b, expected 1", a_in_ready); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %b, expected 1", b_in_ready); end
  endtask

  task automatic test_sweep();
    int first;
    int last;
    int nval;
    first = -1; last = -1; nval = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        a_in_valid = 1'b1;
        a_in_sel   = 3'(i);
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
      if (a_out_valid) begin
        if (first < 0) first = i;
        last = i;
        nval++;
      end
    end
    n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL sweep_latency: first valid after tick %0d, expected 2", first); end
    n_cmp++; if (nval !== 8) begin n_bad++; $display("FAIL sweep_count: got %0d valid cycles, expected 8", nval); end
    n_cmp++; if (last !== 9) begin n_bad++; $display("FAIL sweep_last: last valid after tick %0d, expected 9", last); end
    n_cmp++; if (qa.size() != 0) begin n_bad++; $display("FAIL sweep_drain: %0d words pending, expected 0", qa.size()); end
  endtask

  task automatic test_backpressure();
    int bp_sel[4] = '{5, 2, 7, 0};
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 3'(bp_sel[i]);
      n_cmp++;
      if (a_in_ready !== (i < 3)) begin
        n_bad++;
        $display("FAIL bp_in_ready_%0d: got %b, expected %b", i, a_in_ready, (i < 3));
      end
      if (i < 3) tick();
    end
    repeat (2) tick();
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b, expected 0", a_in_ready); end
    n_cmp++; if ({a_out_valid, a_out_idx, a_out_data} !== {1'b1, 3'd5, 8'hA5}) begin
      n_bad++; $display("FAIL bp_head: got v=%b idx=%0d data=%h, expected v=1 idx=5 data=a5", a_out_valid, a_out_idx, a_out_data);
    end
    a_out_ready = 1'b1;
    for (int t = 0; t < 10 && !a_in_ready; t++) tick();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b, expected 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    for (int t = 0; t < 20 && qa.size() != 0; t++) tick();
    repeat (2) tick();
    n_cmp++; if (qa.size() != 0) begin n_bad++; $display("FAIL bp_drain: %0d words pending, expected 0", qa.size()); end
  endtask

  task automatic test_stall_hold();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd3;
    tick();
    a_in_valid = 1'b0;
    for (int t = 0; t < 10 && !a_out_valid; t++) tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({a_out_valid, a_out_idx, a_out_data} !== {1'b1, 3'd3, 8'hA3}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got v=%b idx=%0d data=%h, expected v=1 idx=3 data=a3", i, a_out_valid, a_out_idx, a_out_data);
      end
      tick();
    end
    a_out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (qa.size() != 0) begin n_bad++; $display("FAIL stall_drain: %0d words pending, expected 0", qa.size()); end
  endtask

  task automatic test_bubble();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd1;
    tick();
    a_in_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_ready_a: got %b, expected 1", a_in_ready); end
    a_in_valid = 1'b1;
    a_in_sel   = 3'd4;
    tick();
    a_in_valid = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_ready_b: got %b, expected 1", a_in_ready); end
    tick();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bubble_ready_c: got %b, expected 1", a_in_ready); end
    n_cmp++; if ({a_out_valid, a_out_idx} !== {1'b1, 3'd1}) begin
      n_bad++; $display("FAIL bubble_head: got v=%b idx=%0d, expected v=1 idx=1", a_out_valid, a_out_idx);
    end
    a_out_ready = 1'b1;
    tick();
    n_cmp++; if ({a_out_valid, a_out_idx, a_out_data} !== {1'b1, 3'd4, 8'hA4}) begin
      n_bad++; $display("FAIL bubble_adjacent: got v=%b idx=%0d data=%h, expected v=1 idx=4 data=a4", a_out_valid, a_out_idx, a_out_data);
    end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_empty: got %b, expected 0", a_out_valid); end
  endtask

  task automatic test_pipe0();
    b_out_ready = 1'b1;
    b_in_data   = {16'hBEEF, 16'h1234};
    b_in_sel    = 1'b1;
    b_in_valid  = 1'b1;
    tick();
    b_in_sel = 1'b0;
    n_cmp++; if ({b_out_valid, b_out_idx, b_out_data} !== {1'b1, 1'b1, 16'hBEEF}) begin
      n_bad++; $display("FAIL pipe0_sel1: got v=%b idx=%0d data=%h, expected v=1 idx=1 data=beef", b_out_valid, b_out_idx, b_out_data);
    end
    tick();
    b_in_valid = 1'b0;
    n_cmp++; if ({b_out_valid, b_out_idx, b_out_data} !== {1'b1, 1'b0, 16'h1234}) begin
      n_bad++; $display("FAIL pipe0_sel0: got v=%b idx=%0d data=%h, expected v=1 idx=0 data=1234", b_out_valid, b_out_idx, b_out_data);
    end
    tick();
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL pipe0_empty: got %b, expected 0", b_out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_in_data   = {$urandom, $urandom};
      a_in_sel    = 3'($urandom_range(0, 7));
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_in_data   = $urandom;
      b_in_sel    = 1'($urandom_range(0, 1));
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) tick();
    repeat (2) tick();
    n_cmp++; if (qa.size() != 0) begin n_bad++; $display("FAIL rand_a_drain: %0d words pending, expected 0", qa.size()); end
    n_cmp++; if (qb.size() != 0) begin n_bad++; $display("FAIL rand_b_drain: %0d words pending, expected 0", qb.size()); end
  endtask

  task automatic test_reset_mid();
    load_ramp();
    a_out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 3'(i);
      tick();
    end
    a_in_valid = 1'b0;
    n_cmp++; if ({a_out_valid, a_in_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rmid_full: got v=%b ready=%b, expected v=1 ready=0", a_out_valid, a_in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({a_out_valid, a_out_idx, a_out_data} !== 12'h000) begin
      n_bad++; $display("FAIL rmid_async: got v=%b idx=%0d data=%h, expected all 0", a_out_valid, a_out_idx, a_out_data);
    end
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_cmp++; if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL rmid_release: got ready=%b v=%b, expected ready=1 v=0", a_in_ready, a_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_ramp();
    a_in_sel    = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    b_in_data   = '0;
    b_in_sel    = 1'b0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_stall_hold();
    test_bubble();
    test_pipe0();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised N:1 multiplexer of DATA_W-bit words, built as a binary tree of 2:1 selection levels.
- Optional pipeline registers between levels, with a valid/ready handshake at both ends.
- Successor to the fixed 8:1 single-bit combinational tree. Used wherever a wide channel select must close timing at high clock rates and tolerate downstream backpressure.

Parameters:
- DATA_W, 8, width of each input word and the output word.
- SEL_W, 3, select width; number of inputs N = 2**SEL_W. Legal range 1..6.
- PIPE, 1, 1 = register after every tree level (latency SEL_W cycles); 0 = whole tree combinational with one output register (latency 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*DATA_W  packed inputs; word j occupies bits [j*DATA_W +: DATA_W].
- in_sel  input  SEL_W  index of the word to forward.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts a transfer this cycle (in_valid && in_ready).
- out_data  output  DATA_W  selected word.
- out_idx  output  SEL_W  in_sel value that produced out_data (echo, for checking).
- out_valid  output  1  out_data/out_idx are valid.
- out_ready  input  1  downstream accepts (out_valid && out_ready).

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. While rst=1, every valid flag, every stage data register, out_data, out_idx and out_valid are 0. in_ready reads 1 after reset, because all stages are empty.
- Tree order: level k (k = 0..SEL_W-1) pairs adjacent words. It forwards the even word when sel bit k = 0 and the odd word when it = 1. Level 0 uses in_sel[0] and the final level uses in_sel[SEL_W-1]. Result equals in_data word in_sel.
- PIPE=1, stage registers:
  - Stage k holds N/2**(k+1) words, the select bits not yet consumed (sel[SEL_W-1:k+1]), the full original sel for out_idx, and a valid flag v[k].
  - The last stage drives out_data, out_idx and out_valid = v[SEL_W-1].
- PIPE=0: a single output stage holds the selected word, the sel and the valid flag.
- Stage handshake (bubble-collapsing):
  - stage_ready[last] = out_ready || !v[last].
  - stage_ready[k] = stage_ready[k+1] || !v[k].
  - in_ready = stage_ready[0].
  - A stage loads when its ready is high. The new v[k] = upstream valid (in_valid for stage 0).
  - A stage with ready low holds its data and flag unchanged.
  - The ready chain is combinational; no combinational path exists from in_valid to in_ready.
- Throughput: one word per cycle when out_ready is held 1. Latency = SEL_W cycles (PIPE=1) or 1 cycle (PIPE=0) from accepted input to out_valid.
- Backpressure: with out_ready=0, the pipeline fills. in_ready drops only when every stage is valid, so the block holds up to SEL_W words (PIPE=1). No word is dropped or duplicated, and order is preserved.
- Bubbles: an empty stage accepts upstream data even when downstream is stalled.
- Data stability: out_data and out_idx do not change while out_valid=1 and out_ready=0.
- Simultaneous events: a stage accepts new data in the same cycle its current word moves downstream.
- Stage registers are not cleared on transfer; stale data behind v=0 is don't-care except at reset.
- Reset mid-operation: asserting rst discards all in-flight words asynchronously. out_valid falls without waiting for a clock edge.
- No arithmetic; all widths derive from DATA_W and SEL_W. in_sel is always in range, since N = 2**SEL_W.

Decomposition:
- Shared package mux_pkg: constant MAX_SEL_W = 6 and a function giving the per-level word count (N >> (k+1)).
- One natural sub-module, mux_tree_stage: one tree level parametrised by DATA_W and input word count. It contains the 2:1 selection array, the optional register with valid/ready, and the carried sel bits.
- The top generates SEL_W instances (PIPE=1), or a combinational chain plus one registered stage (PIPE=0).

Test Plan:
- Reset: assert rst mid-stream with 3 words in flight (DATA_W=8, SEL_W=3, PIPE=1) -> out_valid=0, out_data=0, out_idx=0 immediately; in_ready=1 after release.
- Full sweep: in_data word j = 8'hA0+j, in_sel = 0..7 on consecutive cycles, out_ready=1 -> out_data = A0..A7 with out_idx = 0..7, first result 3 cycles after first accept, one result per cycle.
- Backpressure: out_ready=0 while driving 4 valid inputs (sel 5,2,7,0) -> in_ready falls after 3 accepts; release out_ready -> outputs A5,A2,A7,A0 in order, none lost or repeated.
- Stall hold: out_valid=1 with out_ready=0 for 5 cycles -> out_data/out_idx stable throughout.
- Bubble collapse: one input, then 2 idle cycles, then one input, with out_ready=0 -> both words resident in adjacent stages; in_ready stays 1.
- PIPE=0, SEL_W=1, DATA_W=16: in_data = {16'hBEEF, 16'h1234}, sel=1 -> out_data=16'hBEEF after 1 cycle; random valid/ready traffic matches a reference queue model.
